vedic_mac_acc: RTL and testbench



---
 rtl/vedic_pkg.sv | 19 +
 rtl/vedic_mac_pipe_reg.sv | 28 ++
 rtl/vedic_mul32.sv | 22 ++
 rtl/vedic_mac_acc.sv | 104 ++++++++++
 tb/tb_vedic_mac_acc.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/vedic_pkg.sv
// Shared constants and stage payload types for the Vedic MAC datapath.
package vedic_pkg;
  localparam int ACC_W_DEF  = 72;
  localparam int CNT_W_DEF  = 16;
  localparam int OP_W       = 32;
  localparam int PROD_W     = 64;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            last;
  } s1_t;

  typedef struct packed {
    logic [PROD_W-1:0] prod;
    logic              ovf;
    logic              last;
  } s2_t;
endpackage

// File: rtl/vedic_mac_pipe_reg.sv
// Stall-aware valid/data pipeline register; data only loads on a valid beat.
module vedic_mac_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_stall,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (!i_stall) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/vedic_mul32.sv
// 32x32 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier: vertical and crosswise
// 16-bit partial products; o_ovf is the carry beyond 64 bits.
module vedic_mul32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_gnd,
  output logic [63:0] o_prod,
  output logic        o_ovf
);
  logic [31:0] w_p_ll, w_p_hh, w_p_hl, w_p_lh;
  logic [32:0] w_cross;
  logic [64:0] w_full;

  assign w_p_ll  = 32'(i_a[15:0])  * 32'(i_b[15:0]);
  assign w_p_hh  = 32'(i_a[31:16]) * 32'(i_b[31:16]);
  assign w_p_hl  = 32'(i_a[31:16]) * 32'(i_b[15:0]);
  assign w_p_lh  = 32'(i_a[15:0])  * 32'(i_b[31:16]);
  assign w_cross = {1'b0, w_p_hl} + {1'b0, w_p_lh};
  assign w_full  = {1'b0, w_p_hh, w_p_ll} + {16'b0, w_cross, 16'b0} + {64'b0, i_gnd};
  assign o_prod  = w_full[63:0];
  assign o_ovf   = w_full[64];
endmodule

// File: rtl/vedic_mac_acc.sv
// Three-stage multiply-accumulate over in_last-delimited frames.
// Define VEDIC_MAC_SAT_EN to saturate the accumulator instead of wrapping.
// Handshake: a beat moves on a cycle with valid & ready; stall = out_valid & ~out_ready
// freezes every stage and drops in_ready.
module vedic_mac_acc
  import vedic_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);
  logic              w_stall, w_accept;
  s1_t               w_s1_d, w_s1_q;
  s2_t               w_s2_d, w_s2_q;
  logic              w_s1_v, w_s2_v;
  logic [PROD_W-1:0] w_prod;
  logic              w_mul_ovf;
  logic [ACC_W:0]    w_sum;
  logic [ACC_W-1:0]  w_acc_next;
  logic              w_ovf_next;
  logic [CNT_W-1:0]  w_cnt_next;

  logic [ACC_W-1:0]  r_acc, r_out_acc;
  logic              r_ovf, r_out_ovf, r_out_valid;
  logic [CNT_W-1:0]  r_cnt, r_out_count;

  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_accept = in_valid & in_ready;
  assign w_s1_d   = '{a: in_a, b: in_b, last: in_last};

  vedic_mac_pipe_reg #(.W($bits(s1_t))) u_s1 (
    .clk(clk), .rst_n(rst_n), .i_stall(w_stall),
    .i_valid(w_accept), .i_data(w_s1_d), .o_valid(w_s1_v), .o_data(w_s1_q)
  );

  vedic_mul32 u_mul (
    .i_a(w_s1_q.a), .i_b(w_s1_q.b), .i_gnd(1'b0), .o_prod(w_prod), .o_ovf(w_mul_ovf)
  );

  assign w_s2_d = '{prod: w_prod, ovf: w_mul_ovf, last: w_s1_q.last};

  vedic_mac_pipe_reg #(.W($bits(s2_t))) u_s2 (
    .clk(clk), .rst_n(rst_n), .i_stall(w_stall),
    .i_valid(w_s1_v), .i_data(w_s2_d), .o_valid(w_s2_v), .o_data(w_s2_q)
  );

  assign w_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, w_s2_q.prod};
  assign w_ovf_next = r_ovf | w_sum[ACC_W] | w_s2_q.ovf;
  assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
`ifdef VEDIC_MAC_SAT_EN
  // Once pinned at all-ones every later add carries out again, so it sticks.
  assign w_acc_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_out_acc   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
    end else if (!w_stall) begin
      // Unstalled means the held result (if any) is being taken this cycle.
      r_out_valid <= 1'b0;
      if (w_s2_v) begin
        if (w_s2_q.last) begin
          r_out_acc   <= w_acc_next;
          r_out_ovf   <= w_ovf_next;
          r_out_count <= w_cnt_next;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_ovf       <= 1'b0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_acc_next;
          r_ovf <= w_ovf_next;
          r_cnt <= w_cnt_next;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_ovf   = r_out_ovf;
  assign out_count = r_out_count;
endmodule

// File: tb/tb_vedic_mac_acc.sv
// Bench for vedic_mac_acc: a 72-bit/16-bit-count instance and a 64-bit/3-bit-count
// instance share all stimulus; frames are predicted from whole-frame arithmetic.
module tb_vedic_mac_acc;
  localparam int AW_A = 72, CW_A = 16, AW_B = 64, CW_B = 3;
  localparam int EW_A = AW_A + CW_A + 1, EW_B = AW_B + CW_B + 1;
`ifdef VEDIC_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [31:0] in_a = '0, in_b = '0;
  logic            in_ready_a, out_valid_a, out_ovf_a;
  logic [AW_A-1:0] out_acc_a;
  logic [CW_A-1:0] out_count_a;
  logic            in_ready_b, out_valid_b, out_ovf_b;
  logic [AW_B-1:0] out_acc_b;
  logic [CW_B-1:0] out_count_b;

  vedic_mac_acc #(.ACC_W(AW_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_acc(out_acc_a), .out_ovf(out_ovf_a), .out_count(out_count_a)
  );
  vedic_mac_acc #(.ACC_W(AW_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_acc(out_acc_b), .out_ovf(out_ovf_b), .out_count(out_count_b)
  );

  int n_checks = 0, n_pass = 0, n_hs = 0, n_frames = 0;
  logic [EW_A-1:0] exp_q_a[$];
  logic [EW_B-1:0] exp_q_b[$];
  logic [191:0]    f_total = '0;
  int              f_n = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Whole-frame reference: overflow iff the exact sum needs more than ACC_W bits.
  task automatic push_expect();
    logic [AW_A-1:0] acc_a;
    logic [AW_B-1:0] acc_b;
    logic            ovf_a, ovf_b;
    logic [CW_A-1:0] cnt_a;
    logic [CW_B-1:0] cnt_b;
    ovf_a = (f_total >> AW_A) != 0;
    ovf_b = (f_total >> AW_B) != 0;
    acc_a = f_total[AW_A-1:0];
    acc_b = f_total[AW_B-1:0];
    if (SAT && ovf_a) acc_a = '1;
    if (SAT && ovf_b) acc_b = '1;
    cnt_a = CW_A'((f_n > (2**CW_A - 1)) ? (2**CW_A - 1) : f_n);
    cnt_b = CW_B'((f_n > (2**CW_B - 1)) ? (2**CW_B - 1) : f_n);
    exp_q_a.push_back({ovf_a, cnt_a, acc_a});
    exp_q_b.push_back({ovf_b, cnt_b, acc_b});
    n_frames++;
    f_total = '0;
    f_n = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    logic ok;
    logic [63:0] p;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready_a;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
    else begin
      p = 64'(a) * 64'(b);
      f_total = f_total + 192'(p);
      f_n++;
      if (last) push_expect();
    end
  endtask

  task automatic wait_out();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (out_valid_a) break;
    end
    chk("wait_out_valid", out_valid_a, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready) begin
      n_hs++;
      if (exp_q_a.size() == 0) chk("sb_a_unexpected", 1, 0);
      else chk("sb_frame_a", {out_ovf_a, out_count_a, out_acc_a}, exp_q_a.pop_front());
      if (exp_q_b.size() == 0) chk("sb_b_unexpected", 1, 0);
      else chk("sb_frame_b", {out_valid_b, out_ovf_b, out_count_b, out_acc_b},
               {1'b1, exp_q_b.pop_front()});
    end
  end

  initial begin
    logic done;
    int   len;
    #1;
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_acc", out_acc_a, 0);
    chk("rst_out_ovf", out_ovf_a, 0);
    chk("rst_out_count", out_count_a, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Single beat, max operands, latency
    send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk); chk("lat_e1", out_valid_a, 0);
    @(negedge clk); chk("lat_e2", out_valid_a, 0);
    @(negedge clk); chk("lat_e3", out_valid_a, 1);
    chk("single_acc", out_acc_a, 72'hFFFF_FFFE_0000_0001);
    chk("single_cnt", out_count_a, 1);
    chk("single_ovf", out_ovf_a, 0);
    @(negedge clk); chk("single_pulse", out_valid_a, 0);
    idle(3);

    // 4-beat frame then back-to-back single-beat frame
    send_beat(3, 5, 0); send_beat(7, 11, 0); send_beat(0, 32'h123, 0); send_beat(2, 2, 1);
    send_beat(1, 1, 1);
    wait_out();
    chk("b2b_acc0", out_acc_a, 96);
    chk("b2b_cnt0", out_count_a, 4);
    @(negedge clk);
    chk("b2b_valid1", out_valid_a, 1);
    chk("b2b_acc1", out_acc_a, 1);
    idle(5);

    // Backpressure while the 96 result is pending
    out_ready = 1'b0;
    fork
      begin
        send_beat(3, 5, 0); send_beat(7, 11, 0); send_beat(0, 32'h123, 0); send_beat(2, 2, 1);
        send_beat(2, 3, 0); send_beat(4, 5, 1);
      end
      begin
        wait_out();
        for (int k = 0; k < 5; k++) begin
          chk("bp_in_ready", in_ready_a, 0);
          chk("bp_hold", {out_valid_a, out_acc_a}, {1'b1, 72'd96});
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(10);

    // Accumulator overflow: 64-bit instance overflows, 72-bit does not
    for (int i = 0; i < 3; i++) send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, i == 2);
    wait_out();
    chk("ovf_b_flag", out_ovf_b, 1);
    chk("ovf_b_acc", out_acc_b, SAT ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFA_0000_0003);
    chk("ovf_a_flag", out_ovf_a, 0);
    idle(5);

    // Random bubbles within a 10-beat frame of i*i
    for (int i = 1; i <= 10; i++) begin
      send_beat(i, i, i == 10);
      if (i != 10) idle($urandom_range(0, 3));
    end
    wait_out();
    chk("bub_acc", out_acc_a, 385);
    chk("bub_cnt", out_count_a, 10);
    chk("bub_cnt_sat", out_count_b, 7);
    idle(5);

    // Random frames under random backpressure
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 8; f++) begin
          len = $urandom_range(1, 6);
          for (int i = 0; i < len; i++) begin
            send_beat($urandom, $urandom, i == len - 1);
            idle($urandom_range(0, 1));
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    idle(15);

    // Reset mid-frame discards the partial frame
    send_beat(5, 6, 0); send_beat(7, 8, 0);
    rst_n = 1'b0;
    f_total = '0; f_n = 0;
    @(negedge clk);
    chk("mid_rst_outs", {in_ready_a, out_valid_a, out_ovf_a, out_count_a, out_acc_a},
        {1'b1, 1'b0, 1'b0, 16'd0, 72'd0});
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_beat(6, 7, 1);
    wait_out();
    chk("post_rst_acc", out_acc_a, 42);
    chk("post_rst_cnt", out_count_a, 1);
    idle(10);

    chk("sb_drained", {32'(exp_q_a.size()), 32'(exp_q_b.size())}, 0);
    chk("handshake_count", n_hs, n_frames);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
